// File: rtl/operand_fwd_stage_pkg.sv
// ----------------------------------------------------------------------------
// operand_fwd_stage_pkg
//   Shared constants, state encoding and small datapath helpers for the
//   operand forwarding stage.
//   Contents:
//     OPFWD_SEL_W / OPFWD_DATA_W : candidate-select and operand widths
//     opfwd_state_e              : occupancy state (EMPTY / ONE / TWO)
//     mux32_8way                 : 8-input 32-bit candidate mux
//     mux32_2way                 : 2-input 32-bit mux (main reload source)
//     even_parity                : even parity bit of a 32-bit operand
// ----------------------------------------------------------------------------
package operand_fwd_stage_pkg;

    localparam int OPFWD_SEL_W  = 3;
    localparam int OPFWD_DATA_W = 32;

    typedef enum logic [1:0] {
        OPFWD_EMPTY = 2'b00,
        OPFWD_ONE   = 2'b01,
        OPFWD_TWO   = 2'b10
    } opfwd_state_e;

    function automatic logic [OPFWD_DATA_W-1:0] mux32_8way(
        input logic [OPFWD_SEL_W-1:0]          sel,
        input logic [7:0][OPFWD_DATA_W-1:0]    cand
    );
        logic [OPFWD_DATA_W-1:0] res;
        case (sel)
            3'd0:    res = cand[0];
            3'd1:    res = cand[1];
            3'd2:    res = cand[2];
            3'd3:    res = cand[3];
            3'd4:    res = cand[4];
            3'd5:    res = cand[5];
            3'd6:    res = cand[6];
            3'd7:    res = cand[7];
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    function automatic logic [OPFWD_DATA_W-1:0] mux32_2way(
        input logic                    sel,
        input logic [OPFWD_DATA_W-1:0] a,
        input logic [OPFWD_DATA_W-1:0] b
    );
        return sel ? b : a;
    endfunction

    function automatic logic even_parity(input logic [OPFWD_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/operand_fwd_stage_skid_ctrl.sv
// ----------------------------------------------------------------------------
// operand_fwd_stage_skid_ctrl
//   Occupancy FSM of the 2-entry skid buffer. Produces the registered
//   handshake outputs and the load enables for the main and skid registers.
//   Ports:
//     clk, rst_n      : clock, async active-low reset
//     flush           : synchronous flush, forces EMPTY
//     in_valid        : upstream offers an operand
//     out_ready       : downstream consumes this cycle
//     in_ready        : stage can accept (registered, not a function of out_ready)
//     out_valid       : main register holds a valid operand (registered)
//     main_load       : load main register this cycle
//     main_from_skid  : main register reload source is the skid entry
//     skid_load       : load skid register with the incoming operand
// ----------------------------------------------------------------------------
module operand_fwd_stage_skid_ctrl
    import operand_fwd_stage_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic in_valid,
    input  logic out_ready,
    output logic in_ready,
    output logic out_valid,
    output logic main_load,
    output logic main_from_skid,
    output logic skid_load
);

    opfwd_state_e state_r;
    opfwd_state_e state_nx_s;
    logic         in_ready_r;
    logic         out_valid_r;
    logic         in_fire_s;
    logic         out_fire_s;

    assign in_fire_s  = in_valid & in_ready_r;
    assign out_fire_s = out_valid_r & out_ready;
    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;

    // State register; handshake flags are decoded from the next state so they stay registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= OPFWD_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s != OPFWD_TWO);
            out_valid_r <= (state_nx_s != OPFWD_EMPTY);
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_nx_s = state_r;
        if (flush) begin
            state_nx_s = OPFWD_EMPTY;
        end else begin
            case (state_r)
                OPFWD_EMPTY: begin
                    if (in_fire_s) state_nx_s = OPFWD_ONE;
                    else           state_nx_s = OPFWD_EMPTY;
                end
                OPFWD_ONE: begin
                    if (in_fire_s && !out_fire_s)      state_nx_s = OPFWD_TWO;
                    else if (!in_fire_s && out_fire_s) state_nx_s = OPFWD_EMPTY;
                    else                               state_nx_s = OPFWD_ONE;
                end
                OPFWD_TWO: begin
                    if (out_fire_s) state_nx_s = OPFWD_ONE;
                    else            state_nx_s = OPFWD_TWO;
                end
                default: state_nx_s = OPFWD_EMPTY;
            endcase
        end
    end

    // Load enables: new operand goes to main when main is free or freed, otherwise to skid.
    always_comb begin
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            main_load      = 1'b0;
            main_from_skid = 1'b0;
            skid_load      = 1'b0;
        end else begin
            case (state_r)
                OPFWD_EMPTY: begin
                    main_load = in_fire_s;
                end
                OPFWD_ONE: begin
                    if (in_fire_s && out_fire_s) main_load = 1'b1;
                    else if (in_fire_s)          skid_load = 1'b1;
                    else                         main_load = 1'b0;
                end
                OPFWD_TWO: begin
                    if (out_fire_s) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end else begin
                        main_load      = 1'b0;
                    end
                end
                default: begin
                    main_load      = 1'b0;
                    main_from_skid = 1'b0;
                    skid_load      = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/operand_fwd_stage.sv
// ----------------------------------------------------------------------------
// operand_fwd_stage
//   Registered operand-forwarding stage with a 2-entry skid buffer. Selects
//   one of eight 32-bit forwarding candidates, captures it with its tag and
//   presents it downstream under a valid/ready handshake, in FIFO order.
//   Optional feature macro: OPFWD_PARITY_EN (stores even parity per entry and
//   drives out_parity; otherwise out_parity is tied 0).
//   Ports:
//     clk, rst_n            : clock, async active-low reset
//     flush                 : synchronous flush, empties the stage
//     in_valid / in_ready   : upstream handshake
//     in_sel, in_tag        : candidate select (0=a..7=h) and sideband tag
//     in_a .. in_h          : forwarding candidates
//     out_valid / out_ready : downstream handshake
//     out_data, out_tag     : selected operand and its tag
//     out_parity            : even parity of out_data
// ----------------------------------------------------------------------------
module operand_fwd_stage
    import operand_fwd_stage_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OPFWD_SEL_W-1:0]  in_sel,
    input  logic [TAG_W-1:0]        in_tag,
    input  logic [OPFWD_DATA_W-1:0] in_a,
    input  logic [OPFWD_DATA_W-1:0] in_b,
    input  logic [OPFWD_DATA_W-1:0] in_c,
    input  logic [OPFWD_DATA_W-1:0] in_d,
    input  logic [OPFWD_DATA_W-1:0] in_e,
    input  logic [OPFWD_DATA_W-1:0] in_f,
    input  logic [OPFWD_DATA_W-1:0] in_g,
    input  logic [OPFWD_DATA_W-1:0] in_h,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OPFWD_DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]        out_tag,
    output logic                    out_parity
);

    logic [7:0][OPFWD_DATA_W-1:0] cand_s;
    logic [OPFWD_DATA_W-1:0]      sel_data_s;
    logic                         main_load_s;
    logic                         main_from_skid_s;
    logic                         skid_load_s;
    logic [OPFWD_DATA_W-1:0]      main_data_r;
    logic [TAG_W-1:0]             main_tag_r;
    logic [OPFWD_DATA_W-1:0]      skid_data_r;
    logic [TAG_W-1:0]             skid_tag_r;

    assign cand_s     = {in_h, in_g, in_f, in_e, in_d, in_c, in_b, in_a};
    assign sel_data_s = mux32_8way(in_sel, cand_s);

    operand_fwd_stage_skid_ctrl u_ctrl (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .out_ready      (out_ready),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .main_load      (main_load_s),
        .main_from_skid (main_from_skid_s),
        .skid_load      (skid_load_s)
    );

    // Main entry: refilled from the skid entry when draining TWO, else from the selected candidate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_data_r <= 32'h0000_0000;
            main_tag_r  <= {TAG_W{1'b0}};
        end else if (flush) begin
            main_data_r <= 32'h0000_0000;
            main_tag_r  <= {TAG_W{1'b0}};
        end else if (main_load_s) begin
            main_data_r <= mux32_2way(main_from_skid_s, sel_data_s, skid_data_r);
            main_tag_r  <= main_from_skid_s ? skid_tag_r : in_tag;
        end
    end

    // Skid entry: catches the operand accepted while main is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_data_r <= 32'h0000_0000;
            skid_tag_r  <= {TAG_W{1'b0}};
        end else if (flush) begin
            skid_data_r <= 32'h0000_0000;
            skid_tag_r  <= {TAG_W{1'b0}};
        end else if (skid_load_s) begin
            skid_data_r <= sel_data_s;
            skid_tag_r  <= in_tag;
        end
    end

    assign out_data = main_data_r;
    assign out_tag  = main_tag_r;

`ifdef OPFWD_PARITY_EN
    logic main_par_r;
    logic skid_par_r;
    logic sel_par_s;

    assign sel_par_s = even_parity(sel_data_s);

    // Parity travels with its entry so it stays aligned with out_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_par_r <= 1'b0;
            skid_par_r <= 1'b0;
        end else if (flush) begin
            main_par_r <= 1'b0;
            skid_par_r <= 1'b0;
        end else begin
            if (main_load_s) main_par_r <= main_from_skid_s ? skid_par_r : sel_par_s;
            if (skid_load_s) skid_par_r <= sel_par_s;
        end
    end

    assign out_parity = main_par_r;
`else
    assign out_parity = 1'b0;
`endif

endmodule

// File: tb/tb_operand_fwd_stage.sv
module tb_operand_fwd_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_sel;
    logic [3:0]  in_tag;
    logic [31:0] cand [8];
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_tag;
    logic        out_parity;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  t;
    } ent_t;
    ent_t q[$];

    typedef struct {
        logic       iv;
        logic       ordy;
        logic       fl;
        logic [2:0] sel;
        logic [3:0] tag;
        logic       exp_ov;
        logic       exp_ir;
        logic       chk_dt;
        logic [31:0] exp_d;
        logic [3:0]  exp_t;
    } vec_t;
    vec_t vecs [12];

    always #5 clk = ~clk;

    operand_fwd_stage #(.TAG_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_tag     (in_tag),
        .in_a       (cand[0]),
        .in_b       (cand[1]),
        .in_c       (cand[2]),
        .in_d       (cand[3]),
        .in_e       (cand[4]),
        .in_f       (cand[5]),
        .in_g       (cand[6]),
        .in_h       (cand[7]),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .out_parity (out_parity)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic exp_par(input logic [31:0] d);
`ifdef OPFWD_PARITY_EN
        return ^d;
`else
        return 1'b0 & d[0];
`endif
    endfunction

    // Advance one clock: update the FIFO model from the inputs seen at the edge, then compare.
    task automatic tick();
        bit in_rdy_m;
        bit out_vld_m;
        ent_t e;
        in_rdy_m  = (q.size() < 2);
        out_vld_m = (q.size() > 0);
        e.d = cand[in_sel];
        e.t = in_tag;
        if (flush) begin
            q.delete();
        end else begin
            if (out_vld_m && out_ready) void'(q.pop_front());
            if (in_valid && in_rdy_m) q.push_back(e);
        end
        @(posedge clk);
        #1;
        chk("model_out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("model_in_ready", 64'(in_ready), 64'(q.size() < 2));
        if (q.size() > 0) begin
            chk("model_out_data", 64'(out_data), 64'(q[0].d));
            chk("model_out_tag", 64'(out_tag), 64'(q[0].t));
            chk("model_out_parity", 64'(out_parity), 64'(exp_par(q[0].d)));
        end
    endtask

    task automatic set_in(input logic iv, input logic ordy, input logic fl,
                          input logic [2:0] sel, input logic [3:0] tag);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_sel    = sel;
        in_tag    = tag;
    endtask

    task automatic std_cands();
        for (int i = 0; i < 8; i++) cand[i] = 32'h1000_0000 + 32'(i);
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
        std_cands();

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_out_parity", 64'(out_parity), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Table-driven: backpressure, flush in TWO, simultaneous fire
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'd1, 4'd1, 1'b1, 1'b1, 1'b1, 32'h1000_0001, 4'd1};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 3'd2, 4'd2, 1'b1, 1'b0, 1'b1, 32'h1000_0001, 4'd1};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 3'd3, 4'd3, 1'b1, 1'b0, 1'b1, 32'h1000_0001, 4'd1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 1'b1, 1'b1, 1'b1, 32'h1000_0002, 4'd2};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 4'd0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 3'd4, 4'd4, 1'b1, 1'b1, 1'b1, 32'h1000_0004, 4'd4};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 3'd5, 4'd5, 1'b1, 1'b0, 1'b1, 32'h1000_0004, 4'd4};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 3'd6, 4'd6, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 4'd0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b1, 32'h0000_0000, 4'd0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 3'd7, 4'd7, 1'b1, 1'b1, 1'b1, 32'h1000_0007, 4'd7};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 3'd0, 4'd8, 1'b1, 1'b1, 1'b1, 32'h1000_0000, 4'd8};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 4'd0};
        for (int i = 0; i < 12; i++) begin
            set_in(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].sel, vecs[i].tag);
            tick();
            chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_ov));
            chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_ir));
            if (vecs[i].chk_dt) begin
                chk($sformatf("vec%0d_out_data", i), 64'(out_data), 64'(vecs[i].exp_d));
                chk($sformatf("vec%0d_out_tag", i), 64'(out_tag), 64'(vecs[i].exp_t));
            end
        end

        // Streaming: 8 beats, one per cycle, 1-cycle latency
        for (int i = 0; i < 8; i++) begin
            set_in(1'b1, 1'b1, 1'b0, 3'(i), 4'(i));
            tick();
            chk($sformatf("stream%0d_data", i), 64'(out_data), 64'(32'h1000_0000 + 32'(i)));
            chk($sformatf("stream%0d_in_ready", i), 64'(in_ready), 64'd1);
        end
        set_in(1'b0, 1'b1, 1'b0, 3'd0, 4'd0);
        tick();

        // Simultaneous in_fire and out_fire from ONE
        set_in(1'b1, 1'b0, 1'b0, 3'd2, 4'd3);
        tick();
        cand[5] = 32'hDEAD_BEEF;
        set_in(1'b1, 1'b1, 1'b0, 3'd5, 4'd9);
        tick();
        chk("simul_data", 64'(out_data), 64'h0000_0000_DEAD_BEEF);
        chk("simul_valid", 64'(out_valid), 64'd1);
        chk("simul_in_ready", 64'(in_ready), 64'd1);
        set_in(1'b0, 1'b1, 1'b0, 3'd0, 4'd0);
        tick();
        std_cands();

        // Parity
        cand[0] = 32'h0000_0007;
        cand[1] = 32'h0000_0003;
        set_in(1'b1, 1'b1, 1'b0, 3'd0, 4'd1);
        tick();
`ifdef OPFWD_PARITY_EN
        chk("parity_7", 64'(out_parity), 64'd1);
`else
        chk("parity_7", 64'(out_parity), 64'd0);
`endif
        set_in(1'b1, 1'b1, 1'b0, 3'd1, 4'd2);
        tick();
        chk("parity_3", 64'(out_parity), 64'd0);
        set_in(1'b0, 1'b1, 1'b0, 3'd0, 4'd0);
        tick();
        std_cands();

        // Reset asserted mid-cycle while in TWO
        set_in(1'b1, 1'b0, 1'b0, 3'd3, 4'd3);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 3'd4, 4'd4);
        tick();
        chk("pre_rst_in_ready", 64'(in_ready), 64'd0);
        set_in(1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_data", 64'(out_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);

        // Randomized against the FIFO model
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 8; i++) cand[i] = $urandom;
            set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                   1'($urandom_range(0, 19) == 0), 3'($urandom_range(0, 7)),
                   4'($urandom_range(0, 15)));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
